aes_round_sched: RTL
====================

Name: aes_round_sched

Overview:
- Sequencing controller for the iterative AES round datapath and its on-the-fly key-schedule unit.
- Accepts one block request per handshake and steps the datapath through the initial AddRoundKey and NUM_ROUNDS rounds. It drives round index, final-round select and Rcon, then holds the result-valid flag until downstream accepts.
- Sits between the block request interface and the round/key datapath; it does not touch any 128-bit data.

Parameters:
- NUM_ROUNDS, 10, rounds per block; legal values are 10, 12 and 14 (elaboration error otherwise).
- IDX_W, 4, width of round_idx; must satisfy 2**IDX_W > NUM_ROUNDS.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request carries plaintext/key on the datapath inputs.
- in_key_new  in  1  qualifies in_valid: 1 = load new key, 0 = reuse stored key.
- in_ready  out  1  controller can accept a request.
- flush  in  1  synchronous abort.
- dp_load  out  1  datapath captures plaintext XOR round key 0.
- ks_load  out  1  key schedule captures the key.
- ks_sel_new  out  1  key source for ks_load: 1 = input key, 0 = stored master key.
- dp_round_en  out  1  datapath executes one round this cycle.
- dp_final  out  1  current round omits MixColumns.
- ks_step  out  1  key schedule advances one round key.
- rcon  out  8  round constant for the current ks_step.
- round_idx  out  IDX_W  current round number (0 when idle).
- out_valid  out  1  ciphertext on the datapath output is valid.
- out_ready  in  1  downstream accepts ciphertext.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, ROUND, FINAL, DONE.
- Reset (rst_n=0 at an edge) sets:
  - state=IDLE, round_idx=0, rcon=8'h01;
  - out_valid=0, busy=0;
  - all dp_*/ks_* strobes 0.
- in_ready = (state==IDLE) && rst_n, so in_ready is 0 while reset is asserted.
- Accept: in_valid && in_ready (combinational).
  - dp_load=1, ks_load=1, ks_sel_new=in_key_new in the same cycle.
  - Next state: ROUND with round_idx=1, rcon=8'h01; NUM_ROUNDS==1 is illegal.
- ROUND, each cycle:
  - dp_round_en=1, ks_step=1, dp_final=0.
  - round_idx increments; rcon <= xtime(rcon), where xtime = shift left 1, XOR 8'h1B if the MSB was set.
  - When round_idx==NUM_ROUNDS-1, next state is FINAL.
- FINAL, exactly one cycle:
  - dp_round_en=1, ks_step=1, dp_final=1, round_idx=NUM_ROUNDS.
  - Next state: DONE.
- DONE:
  - out_valid=1; round_idx holds NUM_ROUNDS; no strobes asserted.
  - out_ready=1 moves to IDLE; round_idx=0 and rcon=8'h01 next cycle.
  - out_valid stays high and stable while out_ready=0.
- Latency: acceptance edge E0; out_valid first high in the cycle after edge E(NUM_ROUNDS).
- Throughput: one block per NUM_ROUNDS+2 cycles when out_ready is tied high. in_ready is not asserted in DONE; there is no overlap.
- Rcon sequence for steps 1..14: 01 02 04 08 10 20 40 80 1B 36 6C D8 AB 4D.
- Key handling: the key schedule retains the master key. ks_sel_new=0 rewinds from it, so back-to-back blocks with one key need no reload.
- in_key_new is ignored when in_valid=0.
- flush=1 in any state:
  - next state IDLE, round_idx=0, rcon=8'h01, out_valid=0 next cycle.
  - During the flush cycle all dp_*/ks_* strobes are forced 0 and in_ready is forced 0.
- Reset has priority over flush; flush has priority over accept.
- Reset or flush mid-ROUND discards the block. No out_valid is produced for it, and the next request must assert in_key_new=1 if the key was never loaded since reset.
- in_valid high outside IDLE is ignored; the requester holds the request until in_ready.

Decomposition:
- Package aes_sched_pkg holds:
  - state enum type;
  - RCON_INIT = 8'h01;
  - AES_POLY_LOW = 8'h1B;
  - xtime function;
  - legal NUM_ROUNDS constants (10/12/14).
- Sub-module aes_rcon_gen: an 8-bit register with clear (to 8'h01) and step (xtime) inputs, instantiated once.

Test Plan:
- Reset, then in_valid=1, in_key_new=1 -> dp_load/ks_load/ks_sel_new=1 in that cycle. round_idx steps 1..10; rcon 01..36; dp_final high only at idx 10. out_valid rises 10 cycles after acceptance.
- out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, round_idx=10, no strobes, in_ready=0. Raising out_ready returns to IDLE next cycle with in_ready=1.
- Two back-to-back requests, second with in_key_new=0, out_ready tied 1 -> second accept 12 cycles after the first. ks_sel_new=0 on the second; identical strobe pattern.
- flush pulsed at round_idx=5 -> strobes 0 that cycle, IDLE next cycle. out_valid never asserted; round_idx=0, rcon=01.
- rst_n=0 for one cycle at round_idx=7 with flush=1 -> in_ready=0 during reset, IDLE after, all outputs at reset values.
- NUM_ROUNDS=14 -> rcon reaches 4D at step 14, dp_final only at idx 14, latency 14 cycles.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES round sequencing controller.
//   state_e       : controller state encoding
//   RCON_INIT     : round constant for the first key-schedule step
//   AES_POLY_LOW  : low byte of the AES field polynomial x^8+x^4+x^3+x+1
//   NR_AES*       : legal round counts for 128/192/256-bit keys
//   xtime()       : multiply by x in GF(2^8)
package aes_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_e;

  localparam logic [7:0] RCON_INIT    = 8'h01;
  localparam logic [7:0] AES_POLY_LOW = 8'h1B;

  localparam int unsigned NR_AES128 = 10;
  localparam int unsigned NR_AES192 = 12;
  localparam int unsigned NR_AES256 = 14;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_LOW : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register for the key schedule.
//   clk     : rising-edge clock
//   clear_i : load RCON_INIT (has priority over step_i)
//   step_i  : advance to xtime(rcon)
//   rcon_o  : current round constant
module aes_rcon_gen
  import aes_sched_pkg::*;
(
  input  logic       clk,
  input  logic       clear_i,
  input  logic       step_i,
  output logic [7:0] rcon_o
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (clear_i) begin
      rcon_d = RCON_INIT;
    end else if (step_i) begin
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk) begin
    rcon_q <= rcon_d;
  end

  assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_sched.sv
// Sequencing controller for an iterative AES round datapath with an
// on-the-fly key schedule. Accepts one block per handshake, issues the
// initial AddRoundKey load, NUM_ROUNDS round strobes (last one marked
// final), then holds out_valid until out_ready.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : request handshake; in_key_new selects key source
//   flush                 : synchronous abort back to IDLE
//   dp_load/ks_load       : capture plaintext^key0 / key, on acceptance
//   ks_sel_new            : key source for ks_load (1 = input key)
//   dp_round_en/ks_step   : execute one round / advance one round key
//   dp_final              : current round omits MixColumns
//   rcon, round_idx       : round constant and round number
//   out_valid/out_ready   : result handshake
//   busy                  : controller not in IDLE
module aes_round_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_key_new,
  output logic             in_ready,
  input  logic             flush,
  output logic             dp_load,
  output logic             ks_load,
  output logic             ks_sel_new,
  output logic             dp_round_en,
  output logic             dp_final,
  output logic             ks_step,
  output logic [7:0]       rcon,
  output logic [IDX_W-1:0] round_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  if (!(NUM_ROUNDS == NR_AES128 || NUM_ROUNDS == NR_AES192 ||
        NUM_ROUNDS == NR_AES256)) begin : g_bad_rounds
    $error("aes_round_sched: NUM_ROUNDS must be 10, 12 or 14");
  end

  if ((64'd1 << IDX_W) <= 64'(NUM_ROUNDS)) begin : g_bad_idx_w
    $error("aes_round_sched: IDX_W too narrow for NUM_ROUNDS");
  end

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_ROUNDS);
  localparam logic [IDX_W-1:0] IDX_PENUL = IDX_W'(NUM_ROUNDS - 1);

  state_e           state_q;
  logic [IDX_W-1:0] round_idx_q;
  logic             run_q;
  logic             final_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             accept;
  logic             rcon_clear;
  logic             rcon_step;

  assign in_ready = (state_q == ST_IDLE) && rst_n && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      round_idx_q <= '0;
      run_q       <= 1'b0;
      final_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      round_idx_q <= '0;
      run_q       <= 1'b0;
      final_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q     <= ST_ROUND;
            round_idx_q <= IDX_W'(1);
            run_q       <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_ROUND: begin
          round_idx_q <= round_idx_q + IDX_W'(1);
          if (round_idx_q == IDX_PENUL) begin
            state_q <= ST_FINAL;
            final_q <= 1'b1;
          end
        end
        ST_FINAL: begin
          state_q     <= ST_DONE;
          round_idx_q <= IDX_LAST;
          run_q       <= 1'b0;
          final_q     <= 1'b0;
          out_valid_q <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            round_idx_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Round strobes come from registered state but are masked by flush so an
  // abort cycle never advances the datapath or key schedule.
  assign dp_load     = accept;
  assign ks_load     = accept;
  assign ks_sel_new  = accept && in_key_new;
  assign dp_round_en = run_q && !flush;
  assign ks_step     = run_q && !flush;
  assign dp_final    = final_q && !flush;
  assign round_idx   = round_idx_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;

  assign rcon_clear = !rst_n || flush || accept ||
                      ((state_q == ST_DONE) && out_ready);
  assign rcon_step  = run_q;

  aes_rcon_gen u_rcon (
    .clk     (clk),
    .clear_i (rcon_clear),
    .step_i  (rcon_step),
    .rcon_o  (rcon)
  );

endmodule
